// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard sequencer: per-stage control bundle and FSM states.
// Optional counter bank is enabled by defining PIPE_PERF_CNT_EN.
package pipe_hazard_ctrl_pkg;

    localparam int HZ_PC_W = 64;

    typedef enum logic [0:0] {
        HZ_RUN  = 1'b0,
        HZ_PEND = 1'b1
    } hz_state_t;

    typedef struct packed {
        logic               stall_f;
        logic               stall_d;
        logic               stall_e;
        logic               stall_m;
        logic               flush_d;
        logic               flush_e;
        logic               flush_m;
        logic               redirect;
        logic [HZ_PC_W-1:0] redirect_pc;
    } hazard_ctl_t;

endpackage

// File: rtl/pipe_hazard_ctrl_perf_cnt.sv
// Free-running wrapping event counters for the hazard sequencer.
// Only built when PIPE_PERF_CNT_EN is defined.
`ifdef PIPE_PERF_CNT_EN
module pipe_perf_cnt #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall_ev,
    input  logic             flush_ev,
    output logic [CNT_W-1:0] perf_cycles,
    output logic [CNT_W-1:0] perf_stall,
    output logic [CNT_W-1:0] perf_flush
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // Counter bank: cycles always, stall/flush on their qualifying events.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_cycles <= {CNT_W{1'b0}};
            perf_stall  <= {CNT_W{1'b0}};
            perf_flush  <= {CNT_W{1'b0}};
        end else begin
            perf_cycles <= perf_cycles + CNT_ONE;
            if (stall_ev) begin
                perf_stall <= perf_stall + CNT_ONE;
            end else begin
                perf_stall <= perf_stall;
            end
            if (flush_ev) begin
                perf_flush <= perf_flush + CNT_ONE;
            end else begin
                perf_flush <= perf_flush;
            end
        end
    end

endmodule
`endif

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline, with a parked-redirect FSM.
// Define PIPE_PERF_CNT_EN to add the perf_cycles/perf_stall/perf_flush counters.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int XLEN  = 64
`ifdef PIPE_PERF_CNT_EN
    , parameter int CNT_W = 32
`endif
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load_use,
    input  logic            ex_busy,
    input  logic            d_wait,
    input  logic            i_wait,
    input  logic            br_valid,
    input  logic [XLEN-1:0] br_target,
    output logic            stall_f,
    output logic            stall_d,
    output logic            stall_e,
    output logic            stall_m,
    output logic            flush_d,
    output logic            flush_e,
    output logic            flush_m,
    output logic            redirect,
    output logic [XLEN-1:0] redirect_pc,
    output logic            busy_pend
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] perf_cycles,
    output logic [CNT_W-1:0] perf_stall,
    output logic [CNT_W-1:0] perf_flush
`endif
);

    hz_state_t   state_r, state_nxt_s;
    logic [XLEN-1:0] target_r, target_nxt_s;
    hazard_ctl_t ctl_raw_s, ctl_s;
    logic        accept_s;

    // A branch is only taken when execute is not frozen by memory or a multi-cycle op.
    assign accept_s = br_valid & ~d_wait & ~ex_busy;

    // Priority hazard resolution plus redirect FSM next-state logic.
    always_comb begin
        ctl_raw_s    = '0;
        state_nxt_s  = state_r;
        target_nxt_s = target_r;

        if (d_wait) begin
            ctl_raw_s.stall_f = 1'b1;
            ctl_raw_s.stall_d = 1'b1;
            ctl_raw_s.stall_e = 1'b1;
            ctl_raw_s.stall_m = 1'b1;
        end else if (ex_busy) begin
            ctl_raw_s.stall_f = 1'b1;
            ctl_raw_s.stall_d = 1'b1;
            ctl_raw_s.stall_e = 1'b1;
            ctl_raw_s.flush_m = 1'b1;
        end else if (br_valid) begin
            ctl_raw_s.flush_d = 1'b1;
            ctl_raw_s.flush_e = 1'b1;
        end else if (load_use) begin
            ctl_raw_s.stall_f = 1'b1;
            ctl_raw_s.stall_d = 1'b1;
            ctl_raw_s.flush_e = 1'b1;
        end else begin
            ctl_raw_s.stall_f = i_wait;
        end

        case (state_r)
            HZ_RUN: begin
                if (accept_s && i_wait) begin
                    target_nxt_s = br_target;
                    state_nxt_s  = HZ_PEND;
                end else if (accept_s) begin
                    ctl_raw_s.redirect    = 1'b1;
                    ctl_raw_s.redirect_pc = HZ_PC_W'(br_target);
                end else begin
                    state_nxt_s = HZ_RUN;
                end
            end
            HZ_PEND: begin
                // Stale fetches are discarded while parked; a frozen memory stage still wins.
                ctl_raw_s.flush_d = ctl_raw_s.flush_d | ~d_wait;
                if (i_wait) begin
                    target_nxt_s = accept_s ? br_target : target_r;
                end else begin
                    ctl_raw_s.redirect    = 1'b1;
                    ctl_raw_s.redirect_pc = HZ_PC_W'(accept_s ? br_target : target_r);
                    state_nxt_s           = HZ_RUN;
                end
            end
            default: begin
                state_nxt_s = HZ_RUN;
            end
        endcase
    end

    // Force every control quiet while reset is held.
    always_comb begin
        if (!reset) begin
            ctl_s = '0;
        end else begin
            ctl_s = ctl_raw_s;
        end
    end

    // FSM state and parked redirect target.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r  <= HZ_RUN;
            target_r <= {XLEN{1'b0}};
        end else begin
            state_r  <= state_nxt_s;
            target_r <= target_nxt_s;
        end
    end

    assign stall_f     = ctl_s.stall_f;
    assign stall_d     = ctl_s.stall_d;
    assign stall_e     = ctl_s.stall_e;
    assign stall_m     = ctl_s.stall_m;
    assign flush_d     = ctl_s.flush_d;
    assign flush_e     = ctl_s.flush_e;
    assign flush_m     = ctl_s.flush_m;
    assign redirect    = ctl_s.redirect;
    assign redirect_pc = XLEN'(ctl_s.redirect_pc);
    assign busy_pend   = (state_r == HZ_PEND);

`ifdef PIPE_PERF_CNT_EN
    pipe_perf_cnt #(
        .CNT_W (CNT_W)
    ) u_perf_cnt (
        .clk         (clk),
        .reset       (reset),
        .stall_ev    (ctl_s.stall_d),
        .flush_ev    (ctl_s.flush_d | ctl_s.flush_e),
        .perf_cycles (perf_cycles),
        .perf_stall  (perf_stall),
        .perf_flush  (perf_flush)
    );
`endif

endmodule
